// File: rtl/sipo.sv
// Serial-in/parallel-out reassembler: 2-bit symbols MSB-first into WORD_W-bit words on a valid/ready register.
// Optional idle timeout for partial words is compiled in with `define SIPO_TIMEOUT_EN.
module sipo #(
  parameter int WORD_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        data_serial_i,
  input  logic              valid_serial_i,
  input  logic              flush_i,
  input  logic              ready_i,
  output logic [WORD_W-1:0] data_parallel_o,
  output logic              valid_parallel_o,
  output logic              assembling_o,
  output logic              overrun_o,
  output logic              timeout_o
);
  localparam int N     = WORD_W / 2;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  // Output handshake: a word transfers on any cycle with valid_parallel_o & ready_i;
  // data_parallel_o holds while valid_parallel_o=1 and ready_i=0.
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              accept, completes, expire;
  logic [WORD_W-1:0] new_word;

  assign accept    = valid_serial_i & ~flush_i;
  assign completes = accept && (cnt_q == CNT_W'(N - 1));
  assign new_word  = {shift_q[WORD_W-3:0], data_serial_i};

`ifdef SIPO_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              timeout_q;
  logic              idle_cyc;

  assign idle_cyc = (cnt_q != '0) & ~valid_serial_i & ~flush_i;
  assign expire   = idle_cyc && (idle_q == IDLE_W'(TIMEOUT - 1));

  always_comb begin
    idle_d = '0;
    if (idle_cyc && !expire) idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= expire;
    end
  end

  assign timeout_o = timeout_q;
`else
  // Keeps TIMEOUT referenced when the feature is compiled out; always 0.
  assign expire    = 1'b0 & (TIMEOUT == 0);
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (flush_i || expire) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (accept) begin
      shift_d = new_word;
      cnt_d   = completes ? '0 : cnt_q + 1'b1;
    end
    // A completing word loads if the register is free or draining this cycle, else it is dropped.
    if (completes && (!valid_q || ready_i)) begin
      data_d  = new_word;
      valid_d = 1'b1;
    end else begin
      if (valid_q && ready_i) valid_d = 1'b0;
      overrun_d = completes;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_parallel_o  = data_q;
  assign valid_parallel_o = valid_q;
  assign assembling_o     = (cnt_q != '0);
  assign overrun_o        = overrun_q;
endmodule

// File: tb/tb_sipo.sv
// Directed bench for sipo: scoreboard queue of expected words checked on every output transfer.
module tb_sipo;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   data_serial_i = 2'b00;
  logic         valid_serial_i = 1'b0;
  logic         flush_i = 1'b0;
  logic         ready_i = 1'b0;
  logic [W-1:0] data_parallel_o;
  logic         valid_parallel_o;
  logic         assembling_o;
  logic         overrun_o;
  logic         timeout_o;

  logic [W-1:0] exp_q[$];
  int           n_total = 0;
  int           n_pass  = 0;

  sipo #(.WORD_W(W), .TIMEOUT(15)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_serial_i    (data_serial_i),
    .valid_serial_i   (valid_serial_i),
    .flush_i          (flush_i),
    .ready_i          (ready_i),
    .data_parallel_o  (data_parallel_o),
    .valid_parallel_o (valid_parallel_o),
    .assembling_o     (assembling_o),
    .overrun_o        (overrun_o),
    .timeout_o        (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic [1:0] s);
    data_serial_i  = s;
    valid_serial_i = 1'b1;
    tick();
    valid_serial_i = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W / 2 - 1; i >= 0; i--) send_sym(w[2*i +: 2]);
  endtask

  // Scoreboard: every transfer seen between edges must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && valid_parallel_o && ready_i) begin
      if (exp_q.size() == 0) chk("unexpected_word", {16'h0, data_parallel_o}, 32'hFFFF_FFFF);
      else chk("word", {16'h0, data_parallel_o}, {16'h0, exp_q.pop_front()});
    end
  end

  initial begin
    logic [1:0] syms[8];
    syms = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b11, 2'b11, 2'b00, 2'b10};

    // Reset state
    #2;
    chk("rst_valid", {31'h0, valid_parallel_o}, 32'h0);
    chk("rst_data", {16'h0, data_parallel_o}, 32'h0);
    chk("rst_asm", {31'h0, assembling_o}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Back-to-back symbols, ready high
    ready_i = 1'b1;
    exp_q.push_back(16'hD8F2);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("b2b_pre_valid", {31'h0, valid_parallel_o}, 32'h0);
      send_sym(syms[i]);
    end
    chk("b2b_valid", {31'h0, valid_parallel_o}, 32'h1);
    chk("b2b_data", {16'h0, data_parallel_o}, 32'hD8F2);
    tick();
    chk("b2b_valid_drop", {31'h0, valid_parallel_o}, 32'h0);

    // Symbols every third cycle
    exp_q.push_back(16'hD8F2);
    for (int i = 0; i < 8; i++) begin
      send_sym(syms[i]);
      chk("gap_asm", {31'h0, assembling_o}, (i != 7) ? 32'h1 : 32'h0);
      if (i != 7) begin
        tick();
        tick();
        chk("gap_asm_hold", {31'h0, assembling_o}, 32'h1);
      end
    end
    chk("gap_data", {16'h0, data_parallel_o}, 32'hD8F2);
    tick();
    chk("gap_valid_drop", {31'h0, valid_parallel_o}, 32'h0);

    // Overrun: second word dropped while the first is held
    ready_i = 1'b0;
    exp_q.push_back(16'h1234);
    send_word(16'h1234);
    chk("ovr_first_valid", {31'h0, valid_parallel_o}, 32'h1);
    chk("ovr_first_flag", {31'h0, overrun_o}, 32'h0);
    send_word(16'hFFFF);
    chk("ovr_pulse", {31'h0, overrun_o}, 32'h1);
    chk("ovr_data_held", {16'h0, data_parallel_o}, 32'h1234);
    tick();
    chk("ovr_pulse_end", {31'h0, overrun_o}, 32'h0);
    ready_i = 1'b1;
    tick();
    chk("ovr_valid_drop", {31'h0, valid_parallel_o}, 32'h0);
    tick();
    chk("ovr_no_ffff", {31'h0, valid_parallel_o}, 32'h0);

    // Completion coincides with consumption
    ready_i = 1'b0;
    exp_q.push_back(16'h1234);
    send_word(16'h1234);
    exp_q.push_back(16'h5555);
    for (int i = 0; i < 7; i++) send_sym(2'b01);
    ready_i = 1'b1;
    send_sym(2'b01);
    ready_i = 1'b0;
    chk("sim_valid", {31'h0, valid_parallel_o}, 32'h1);
    chk("sim_data", {16'h0, data_parallel_o}, 32'h5555);
    chk("sim_no_ovr", {31'h0, overrun_o}, 32'h0);
    ready_i = 1'b1;
    tick();
    chk("sim_drain", {31'h0, valid_parallel_o}, 32'h0);

    // Flush beats a simultaneous symbol
    for (int i = 0; i < 3; i++) send_sym(2'b11);
    flush_i = 1'b1;
    send_sym(2'b11);
    flush_i = 1'b0;
    chk("flush_asm", {31'h0, assembling_o}, 32'h0);
    exp_q.push_back(16'hAAAA);
    for (int i = 0; i < 8; i++) send_sym(2'b10);
    chk("flush_data", {16'h0, data_parallel_o}, 32'hAAAA);
    chk("flush_valid", {31'h0, valid_parallel_o}, 32'h1);
    tick();
    chk("flush_one_word", {31'h0, valid_parallel_o}, 32'h0);

    // Asynchronous reset mid-word with a word pending
    ready_i = 1'b0;
    send_word(16'h0F0F);
    for (int i = 0; i < 5; i++) send_sym(2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'h0, valid_parallel_o}, 32'h0);
    chk("arst_data", {16'h0, data_parallel_o}, 32'h0);
    chk("arst_asm", {31'h0, assembling_o}, 32'h0);
    chk("arst_ovr", {31'h0, overrun_o}, 32'h0);
    tick();
    rst_n = 1'b1;
    ready_i = 1'b1;
    exp_q.push_back(16'h5555);
    for (int i = 0; i < 8; i++) send_sym(2'b01);
    chk("arst_word", {16'h0, data_parallel_o}, 32'h5555);
    tick();

    // Idle partial word
    exp_q.push_back(16'h6C00);
    send_sym(2'b01);
    send_sym(2'b10);
    send_sym(2'b11);
`ifdef SIPO_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("to_pulse", {31'h0, timeout_o}, (i == 15) ? 32'h1 : 32'h0);
      chk("to_asm", {31'h0, assembling_o}, (i < 15) ? 32'h1 : 32'h0);
    end
    exp_q.delete();
    exp_q.push_back(16'h0000);
    for (int i = 0; i < 8; i++) send_sym(2'b00);
    chk("to_restart", {16'h0, data_parallel_o}, 32'h0000);
`else
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("noto_pulse", {31'h0, timeout_o}, 32'h0);
    end
    chk("noto_asm", {31'h0, assembling_o}, 32'h1);
    for (int i = 0; i < 5; i++) send_sym(2'b00);
    chk("noto_word", {16'h0, data_parallel_o}, 32'h6C00);
    chk("noto_valid", {31'h0, valid_parallel_o}, 32'h1);
`endif
    tick();
    tick();
    chk("queue_empty", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sipo.md
Name: sipo

Overview:
- Serial-in/parallel-out reassembler; the receive-side counterpart of the 16-bit-to-2-bit symbol serializer.
- Collects 2-bit symbols MSB-first into WORD_W-bit words and presents each completed word on a single-entry valid/ready output register.
- Sits between the decoder's symbol stream and the word-oriented downstream logic.
- Serial input has no backpressure; every symbol presented with valid is consumed.

Parameters:
- WORD_W, 16, output word width; even, >= 4; symbols per word N = WORD_W/2.
- TIMEOUT, 15, idle-cycle limit for a partial word; used only when SIPO_TIMEOUT_EN is defined; >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_serial_i  input  2  symbol; the first symbol of a word lands in bits [WORD_W-1:WORD_W-2].
- valid_serial_i  input  1  symbol valid; consumed the same cycle.
- flush_i  input  1  discard the partial word in progress.
- ready_i  input  1  downstream accepts data_parallel_o.
- data_parallel_o  output  WORD_W  assembled word (registered).
- valid_parallel_o  output  1  output word valid; held until accepted.
- assembling_o  output  1  partial word in progress (symbol count != 0).
- overrun_o  output  1  one-cycle pulse: completed word dropped.
- timeout_o  output  1  one-cycle pulse: partial word discarded by timeout.

Behaviour:
- Reset (async, rst_n=0): shift register=0, symbol count=0, data_parallel_o=0, valid_parallel_o=0, overrun_o=0, timeout_o=0, idle counter=0. Takes effect immediately, including mid-word or with a word pending.
- Accept: on valid_serial_i=1 and flush_i=0, shift_reg <= {shift_reg[WORD_W-3:0], data_serial_i} and cnt <= cnt+1.
- Completion: a symbol accepted with cnt==N-1 completes the word and cnt wraps to 0. The word is {shift_reg[WORD_W-3:0], data_serial_i}. The completing symbol is never lost to the shift.
- Output latency: valid_parallel_o and data_parallel_o update on the clock edge that accepts the N-th symbol, so they are visible the cycle after that symbol is presented.
- Handshake: the output is consumed when valid_parallel_o & ready_i. After consumption valid_parallel_o drops next cycle unless a new word is loaded the same cycle. data_parallel_o is stable while valid=1 and ready=0.
- Simultaneous completion and consumption: the new word loads and valid stays 1. No overrun.
- Completion while valid_parallel_o=1 and ready_i=0:
  - The new word is dropped and the old word is retained.
  - overrun_o=1 for exactly one cycle, on the cycle after the completing symbol.
  - Assembly continues with cnt=0.
- Flush: flush_i=1 sets cnt=0 and shift_reg=0 next cycle.
  - It does not touch the output register.
  - If valid_serial_i arrives in the same cycle, flush wins and that symbol is discarded.
- assembling_o = (cnt != 0), registered-derived; goes high the cycle after the first accepted symbol.
- Back-to-back symbols at full rate are sustained indefinitely with no bubbles.

Optional Feature:
- Macro: SIPO_TIMEOUT_EN.
- When defined:
  - An idle counter increments on every cycle with cnt!=0 and valid_serial_i=0, and clears on any accepted symbol or flush.
  - When it reaches TIMEOUT, the partial word is discarded (cnt=0, shift_reg=0, idle=0) and timeout_o pulses for one cycle.
  - The output register is unaffected.
  - A symbol arriving on the same cycle the counter would reach TIMEOUT is accepted and no timeout occurs.
- When not defined:
  - No idle counter is built and timeout_o is tied 0.
  - A partial word is held indefinitely until completed, flushed or reset.

Test Plan:
- Reset, ready_i=1, 8 back-to-back symbols 11,01,10,00,11,11,00,10 -> data_parallel_o=16'hD8F2, valid_parallel_o high exactly 1 cycle, starting the cycle after the 8th symbol.
- Same symbols with valid_serial_i every 3rd cycle -> same 16'hD8F2. assembling_o is high from the cycle after symbol 1 until the cycle after symbol 8.
- ready_i=0, two consecutive words 16'h1234 then 16'hFFFF:
  - 16'h1234 stays on the output; overrun_o pulses once the cycle after the 16th symbol.
  - Raising ready_i then drops valid after 1 cycle; 16'hFFFF is never presented.
- ready_i=0 with 16'h1234 pending, ready_i pulsed in the same cycle the 8th symbol of 16'h5555 is presented -> no overrun; data becomes 16'h5555 with valid continuous.
- 3 symbols, then flush_i together with a valid symbol, then 8 symbols of 10 -> exactly one word 16'hAAAA; assembling_o is 0 the cycle after the flush.
- rst_n pulsed low after 5 symbols with a word pending -> all outputs 0 immediately; the next 8 symbols of 01 yield 16'h5555.
- With SIPO_TIMEOUT_EN, TIMEOUT=15: 3 symbols then idle -> timeout_o pulses on idle cycle 15 and assembling_o drops. Without the macro -> no pulse, and 5 more symbols complete the word.
